ibpl_out_pulse_gen: RTL and testbench
=====================================

# ibpl_out_pulse_gen

Six-channel timed pulse generator that drives the output cardlet's `internal_out[5:0]` and `output_act[5:0]` inputs on the interbackplane. Each channel turns a single-cycle trigger strobe into a pulse with a programmable start delay and width. Each channel has a polarity setting and a sticky missed-trigger flag. It sits between the blackbox event/trigger logic and the output cardlet.

## Interface
- `NCH`, 6: number of channels; matches the output cardlet's six driven lines.
- `CNT_W`, 16: width of the delay and width counters, in clock cycles.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `trig` in NCH: per-channel single-cycle trigger strobe.
- `ch_en` in NCH: per-channel enable.
- `cfg_delay` in NCH*CNT_W: per-channel start delay D, in cycles; channel i uses bits [i*CNT_W +: CNT_W].
- `cfg_width` in NCH*CNT_W: per-channel pulse width W, in cycles; same packing as `cfg_delay`.
- `cfg_pol` in NCH: 1 inverts the output; the inactive level equals `cfg_pol`.
- `missed_clr` in NCH: clears the sticky missed flag.
- `pulse_out` out NCH: to cardlet `internal_out[5:0]`.
- `pulse_act` out NCH: channel busy; to cardlet `output_act[5:0]`.
- `missed` out NCH: sticky flag, set when a trigger is dropped because the channel is busy.

## Operation
- Each channel runs an independent FSM with states IDLE, DELAY and PULSE.
- **Acceptance.** A trigger is accepted in IDLE when `trig[i]`, `ch_en[i]` and `W != 0` are all true.
  - D and W are latched at acceptance; later config changes do not affect a running pulse.
  - If D > 0 the channel goes to DELAY and loads the counter with D-1.
  - If D == 0 the channel goes straight to PULSE and loads the counter with W-1.
- **DELAY.** The counter decrements. At 0 the channel goes to PULSE and loads W-1.
- **PULSE.** The raw pulse register is 1. The counter decrements. At 0 the channel returns to IDLE and the raw pulse register clears.
- **Output level.** `pulse_out[i] = pulse_raw[i] ^ cfg_pol[i]`. The polarity applies combinationally and is the only combinational path to an output.
- **Activity.** `pulse_act[i]` is 1 whenever the state is not IDLE; it is registered through the state encoding.
- **Rejected triggers.**
  - A trigger in IDLE with `ch_en` = 0 or W = 0 is ignored and leaves no flag.
  - A trigger in DELAY or PULSE is ignored and sets `missed[i]`.
- **Missed flag clear.** `missed_clr[i]` clears the flag. If a set and a clear occur in the same cycle, set wins.
- **Enable drop.** Deasserting `ch_en[i]` in DELAY or PULSE aborts the channel: next cycle it is IDLE with the raw pulse at 0. Any trigger in that same cycle counts as missed.
- **Counter width.** Counters are CNT_W bits and never wrap, because they are only loaded with D-1 or W-1 where the value is at least 1. The maximum is D = W = 2^CNT_W - 1.

## Timing
- **Reset.** All states go to IDLE, counters to 0, `pulse_raw` to 0 and `missed` to 0. Outputs after reset: `pulse_act` = 0, `missed` = 0, `pulse_out` = `cfg_pol`.
- **Reset mid-operation.** The channel aborts with no partial pulse continuing; `pulse_out` returns to its inactive level the cycle after `rst` is sampled.
- **Pulse timing** for a trigger accepted in cycle T:
  - `pulse_act` is high in cycles T+1 through T+D+W inclusive.
  - The pulse is active in cycles T+1+D through T+D+W: exactly W cycles.
- **Back-to-back triggers.** A trigger in cycle T+D+W is missed. A trigger in cycle T+D+W+1 is accepted, which gives the minimum trigger spacing of D+W+1.
- **Missed flag.** `missed` goes high the cycle after the dropped trigger.
- There is no handshake. Triggers are strobes; a trigger held high is sampled every cycle.

## Structure
- Package `ibpl_pulse_pkg` holds:
  - the state enum (IDLE, DELAY, PULSE; 2 bits);
  - `CNT_W_DEFAULT` = 16;
  - `NCH_DEFAULT` = 6.
- Sub-module `ibpl_pulse_channel` implements one FSM, counter, raw pulse register and missed flag. The top level generates NCH instances and applies the polarity XOR.

## Test plan
- **Basic pulse.** Reset, then ch0 with D=3, W=5, pol=0; trigger in cycle 10. Expect `pulse_act` high in cycles 11–18 and `pulse_out` high in cycles 14–18.
- **Zero delay, inverted polarity.** ch1 with D=0, W=1, pol=1; trigger in cycle 20. Expect `pulse_out` = 0 only in cycle 21, otherwise 1; `pulse_act` high in cycle 21 only.
- **Retrigger boundary.** ch2 with D=2, W=2; triggers in cycles 0, 4 and 5. Expect the cycle-4 trigger missed with `missed[2]` = 1 from cycle 5, and the cycle-5 trigger accepted with the pulse in cycles 8–9. Assert `missed_clr` and `trig` together while busy; expect `missed` to stay 1.
- **Rejected triggers.** W=0 trigger on ch3: no activity and no `missed`. `ch_en` = 0 trigger: same.
- **Abort mid-pulse.** ch4 with D=0, W=100; drop `ch_en` in cycle 50 of the pulse. Expect `pulse_act` and `pulse_out` inactive the next cycle. Repeat with `rst` instead of the enable drop; expect `missed` cleared as well.
- **Parallel channels and maximum counts.** All six channels triggered in the same cycle with distinct D/W values: each matches its own timing. Then one channel with D = W = 65535: expect the pulse to start exactly at T+65536 and last 65535 cycles.

Source files
------------

// File: rtl/ibpl_pulse_pkg.sv
// Shared types and defaults for the interbackplane output pulse generator.
package ibpl_pulse_pkg;

  localparam int unsigned CNT_W_DEFAULT = 16;
  localparam int unsigned NCH_DEFAULT   = 6;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDelay = 2'd1,
    StPulse = 2'd2
  } ch_state_e;

endpackage

// File: rtl/ibpl_pulse_channel.sv
// One pulse channel: trigger acceptance, delay/width countdown, raw pulse and sticky missed flag.
module ibpl_pulse_channel
  import ibpl_pulse_pkg::*;
#(
  parameter int unsigned CntW = CNT_W_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            trig_i,
  input  logic            en_i,
  input  logic [CntW-1:0] delay_i,
  input  logic [CntW-1:0] width_i,
  input  logic            missed_clr_i,
  output logic            pulse_raw_o,
  output logic            busy_o,
  output logic            missed_o
);

  ch_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] width_q;
  logic            pulse_q;
  logic            missed_q;
  logic            accept;

  assign accept = trig_i && en_i && (width_i != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      width_q  <= '0;
      pulse_q  <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      // Set has priority over clear.
      if (trig_i && (state_q != StIdle)) begin
        missed_q <= 1'b1;
      end else if (missed_clr_i) begin
        missed_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (accept) begin
            width_q <= width_i;
            if (delay_i != '0) begin
              state_q <= StDelay;
              cnt_q   <= delay_i - CntW'(1);
            end else begin
              state_q <= StPulse;
              cnt_q   <= width_i - CntW'(1);
              pulse_q <= 1'b1;
            end
          end
        end
        StDelay: begin
          if (!en_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
          end else if (cnt_q == '0) begin
            state_q <= StPulse;
            cnt_q   <= width_q - CntW'(1);
            pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StPulse: begin
          if (!en_i || (cnt_q == '0)) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          pulse_q <= 1'b0;
        end
      endcase
    end
  end

  assign pulse_raw_o = pulse_q;
  assign busy_o      = (state_q != StIdle);
  assign missed_o    = missed_q;

endmodule

// File: rtl/ibpl_out_pulse_gen.sv
// Multi-channel timed pulse generator feeding the output cardlet; polarity is the only
// combinational path to an output.
module ibpl_out_pulse_gen
  import ibpl_pulse_pkg::*;
#(
  parameter int unsigned NCH   = NCH_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NCH-1:0]       trig_i,
  input  logic [NCH-1:0]       ch_en_i,
  input  logic [NCH*CNT_W-1:0] cfg_delay_i,
  input  logic [NCH*CNT_W-1:0] cfg_width_i,
  input  logic [NCH-1:0]       cfg_pol_i,
  input  logic [NCH-1:0]       missed_clr_i,
  output logic [NCH-1:0]       pulse_out_o,
  output logic [NCH-1:0]       pulse_act_o,
  output logic [NCH-1:0]       missed_o
);

  logic [NCH-1:0] pulse_raw;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ibpl_pulse_channel #(
      .CntW(CNT_W)
    ) u_ch (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .trig_i      (trig_i[i]),
      .en_i        (ch_en_i[i]),
      .delay_i     (cfg_delay_i[i*CNT_W +: CNT_W]),
      .width_i     (cfg_width_i[i*CNT_W +: CNT_W]),
      .missed_clr_i(missed_clr_i[i]),
      .pulse_raw_o (pulse_raw[i]),
      .busy_o      (pulse_act_o[i]),
      .missed_o    (missed_o[i])
    );
  end

  assign pulse_out_o = pulse_raw ^ cfg_pol_i;

endmodule

// File: tb/tb_ibpl_out_pulse_gen.sv
// Scoreboard bench: stimulus pushes per-cycle expected outputs, a negedge monitor compares.
module tb_ibpl_out_pulse_gen;

  localparam int unsigned NCH   = 6;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned SW    = 8;

  logic clk_i = 1'b0;
  logic rst_i;
  logic [NCH-1:0]       trig, ch_en, cfg_pol, missed_clr, pulse_out, pulse_act, missed;
  logic [NCH*CNT_W-1:0] cfg_delay, cfg_width;
  // Narrow instance (single channel, 8-bit counters) for the all-ones count boundary.
  logic [0:0]    s_trig, s_en, s_pol, s_clr, s_out, s_act, s_mis;
  logic [SW-1:0] s_delay, s_width;

  always #5 clk_i = ~clk_i;

  ibpl_out_pulse_gen #(.NCH(NCH), .CNT_W(CNT_W)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .trig_i(trig), .ch_en_i(ch_en),
    .cfg_delay_i(cfg_delay), .cfg_width_i(cfg_width), .cfg_pol_i(cfg_pol),
    .missed_clr_i(missed_clr), .pulse_out_o(pulse_out), .pulse_act_o(pulse_act),
    .missed_o(missed)
  );

  ibpl_out_pulse_gen #(.NCH(1), .CNT_W(SW)) u_dut_small (
    .clk_i(clk_i), .rst_i(rst_i), .trig_i(s_trig), .ch_en_i(s_en),
    .cfg_delay_i(s_delay), .cfg_width_i(s_width), .cfg_pol_i(s_pol),
    .missed_clr_i(s_clr), .pulse_out_o(s_out), .pulse_act_o(s_act),
    .missed_o(s_mis)
  );

  typedef struct packed {
    logic [6:0] out;
    logic [6:0] act;
    logic [6:0] mis;
    int         cyc;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         cyc = 0;
  // Expected activity/pulse windows per channel; index 6 is the narrow instance.
  int         act_lo[7], act_hi[7], pul_lo[7], pul_hi[7];
  logic [6:0] exp_mis, pend_set, pend_clr;

  function automatic void check(string name, int c, logic [6:0] got, logic [6:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b want %b", name, c, got, want);
    end
  endfunction

  always @(negedge clk_i) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("pulse_out", e.cyc, {s_out, pulse_out}, e.out);
      check("pulse_act", e.cyc, {s_act, pulse_act}, e.act);
      check("missed",    e.cyc, {s_mis, missed},    e.mis);
    end
  end

  task automatic step();
    exp_t       e;
    logic [6:0] pol_all;
    logic       raw;
    pol_all = {s_pol, cfg_pol};
    e.cyc   = cyc;
    e.mis   = exp_mis;
    for (int i = 0; i < 7; i++) begin
      e.act[i] = (cyc >= act_lo[i]) && (cyc <= act_hi[i]);
      raw      = (cyc >= pul_lo[i]) && (cyc <= pul_hi[i]);
      e.out[i] = raw ^ pol_all[i];
    end
    sb_q.push_back(e);
    @(posedge clk_i);
    #1;
    cyc++;
    exp_mis    = (exp_mis & ~pend_clr) | pend_set;
    pend_set   = '0;
    pend_clr   = '0;
    trig       = '0;
    s_trig     = '0;
    missed_clr = '0;
    s_clr      = '0;
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic poke(int ch, int d, int w);
    if (ch < 6) begin
      trig[ch] = 1'b1;
      cfg_delay[ch*CNT_W +: CNT_W] = CNT_W'(d);
      cfg_width[ch*CNT_W +: CNT_W] = CNT_W'(w);
    end else begin
      s_trig  = 1'b1;
      s_delay = SW'(d);
      s_width = SW'(w);
    end
  endtask

  // Accepted trigger in the current cycle T.
  task automatic fire(int ch, int d, int w);
    poke(ch, d, w);
    act_lo[ch] = cyc + 1;
    act_hi[ch] = cyc + d + w;
    pul_lo[ch] = cyc + 1 + d;
    pul_hi[ch] = cyc + d + w;
  endtask

  // Trigger while busy: dropped, flag set next cycle.
  task automatic fire_busy(int ch);
    if (ch < 6) trig[ch] = 1'b1;
    else s_trig = 1'b1;
    pend_set[ch] = 1'b1;
  endtask

  task automatic clamp(int ch);
    if (act_hi[ch] > cyc) act_hi[ch] = cyc;
    if (pul_hi[ch] > cyc) pul_hi[ch] = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int dtab[6] = '{1, 0, 4, 2, 7, 3};
  int wtab[6] = '{3, 6, 1, 5, 2, 4};

  initial begin
    for (int i = 0; i < 7; i++) begin
      act_lo[i] = 0; act_hi[i] = -1; pul_lo[i] = 0; pul_hi[i] = -1;
    end
    exp_mis = '0; pend_set = '0; pend_clr = '0;
    rst_i = 1'b1;
    trig = '0; ch_en = '1; cfg_pol = 6'b010010; missed_clr = '0;
    cfg_delay = '0; cfg_width = '0;
    s_trig = '0; s_en = 1'b1; s_pol = 1'b0; s_clr = '0; s_delay = '0; s_width = '0;

    @(posedge clk_i);
    #1;
    cyc = 0;
    step();
    rst_i = 1'b0;
    run(9);

    // Basic pulse; config changes after acceptance must not matter.
    fire(0, 3, 5);
    run(2);
    cfg_width[0 +: CNT_W] = 16'd1;
    cfg_delay[0 +: CNT_W] = 16'd0;
    run(8);

    // Zero delay, inverted polarity.
    fire(1, 0, 1);
    run(10);

    // Retrigger boundary and set-beats-clear.
    fire(2, 2, 2);
    run(4);
    fire_busy(2);
    step();
    fire(2, 2, 2);
    run(2);
    fire_busy(2);
    missed_clr[2] = 1'b1;
    pend_clr[2]   = 1'b1;
    run(5);
    missed_clr[2] = 1'b1;
    pend_clr[2]   = 1'b1;
    run(3);

    // Rejected triggers: zero width, then channel disabled.
    poke(3, 1, 0);
    run(4);
    ch_en[3] = 1'b0;
    poke(3, 1, 4);
    step();
    ch_en[3] = 1'b1;
    run(3);

    // Enable drop in the 50th pulse cycle, with a trigger in the same cycle.
    fire(4, 0, 100);
    run(50);
    ch_en[4] = 1'b0;
    fire_busy(4);
    clamp(4);
    step();
    ch_en[4] = 1'b1;
    run(5);

    // Reset mid-pulse clears state and the missed flag.
    fire(4, 0, 100);
    run(31);
    rst_i = 1'b1;
    for (int i = 0; i < 7; i++) clamp(i);
    pend_clr = '1;
    step();
    rst_i = 1'b0;
    run(4);

    // All channels at once, with a polarity change on the same cycle.
    cfg_pol = 6'b101001;
    for (int i = 0; i < 6; i++) fire(i, dtab[i], wtab[i]);
    run(15);

    // All-ones counts on the narrow instance; wide counts on ch5.
    fire(6, 255, 255);
    fire(5, 300, 300);
    run(510);
    fire_busy(6);
    step();
    fire(6, 1, 1);
    run(94);

    @(negedge clk_i);
    #1;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
